branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised dynamic conditional-branch predictor that replaces the single-bit global prediction flop.
- Holds a pattern history table (PHT) of saturating counters. It can run in bimodal mode or in gshare mode, where a global history register is XORed into the index.
- Decode queries it combinationally for conditional branches. Execute writes back the resolved outcome using the index carried down the pipe.
- A table-initialisation sweep after reset models a RAM-backed PHT. Saturating performance counters report branch and mispredict totals.

Parameters:
INDEX_BITS, 6, log2 of PHT entries (64 entries); legal 2..12
CTR_BITS, 2, width of each saturating counter; legal 1..4
HIST_BITS, 4, global history length; legal 0..INDEX_BITS; ignored in bimodal mode
MODE, BP_GSHARE, predictor mode of type bp_mode_t (BP_BIMODAL or BP_GSHARE)
INIT_CTR, 1, counter value written by the init sweep; must be below 2**CTR_BITS (1 = weakly not-taken for 2-bit counters)

Ports:
Clock  input  1  system clock, rising edge
nReset  input  1  asynchronous active-low reset
predValid  input  1  decode holds a conditional branch this cycle
predPC  input  32  PC of the decode-stage branch
predTaken  output  1  predicted direction (combinational)
predIndex  output  INDEX_BITS  PHT index used for this prediction; core pipelines it to execute
ready  output  1  init sweep complete; table valid
updValid  input  1  execute resolves a conditional branch this cycle
updIndex  input  INDEX_BITS  index returned from execute (predIndex captured at decode)
updTaken  input  1  resolved direction
updMispredict  input  1  resolved direction differed from the prediction
clearStats  input  1  synchronous clear of the performance counters
branchCount  output  32  resolved conditional branches, saturating
mispredictCount  output  32  mispredicts, saturating

Behaviour:
- Clocking and reset:
  - Clock is the only clock. nReset is asynchronous, active-low.
  - On reset: FSM goes to INIT; sweep pointer = 0; GHR = 0; branchCount = 0; mispredictCount = 0; ready = 0. PHT contents are undefined until the sweep completes.
- FSM, two states:
  - INIT: each cycle writes INIT_CTR to PHT[ptr] and increments ptr. When ptr = 2**INDEX_BITS-1 is written, the next state is RUN.
  - ready rises exactly 2**INDEX_BITS cycles after the first rising edge following nReset deassertion.
  - RUN: ready = 1; stays in RUN until reset.
  - Reset asserted mid-sweep or mid-RUN restarts the sweep from ptr = 0.
- Index:
  - Bimodal: idx = predPC[INDEX_BITS+1:2].
  - Gshare: idx = predPC[INDEX_BITS+1:2] XOR zero-extended GHR[HIST_BITS-1:0].
  - HIST_BITS = 0 degenerates gshare to bimodal.
  - predIndex = idx at all times, independent of predValid and ready.
- Prediction:
  - predTaken = MSB of PHT[idx] when ready && predValid, else 0.
  - Zero latency; purely combinational read.
- Update (RUN only; updValid in INIT is ignored entirely, including stats):
  - PHT[updIndex]: incremented if updTaken, else decremented.
  - Counter saturates at 2**CTR_BITS-1 and at 0; no wrap.
  - Gshare: GHR <= {GHR[HIST_BITS-2:0], updTaken} on each valid update. The GHR is non-speculative.
- Same-cycle read and update of the same entry: the prediction sees the pre-update value (read-before-write). The new value is visible the following cycle.
- Performance counters:
  - branchCount increments on every RUN-state updValid.
  - mispredictCount increments when updValid && updMispredict.
  - Both hold at 32'hFFFF_FFFF.
  - clearStats has priority over a same-cycle increment: the counter becomes 0, not 1.
- No backpressure. One prediction and one update per cycle are always accepted.

Decomposition:
- Shared package (coreUtils):
  - bp_mode_t enum {BP_BIMODAL, BP_GSHARE}.
  - bp_state_t enum {BP_INIT, BP_RUN}.
  - Function sat_update(ctr, taken, width) for saturating increment/decrement.
- Sub-module pht_table: a 2**INDEX_BITS x CTR_BITS register array with one async read port, one write port and read-before-write semantics.
- FSM, GHR, indexing and stats live in branch_predictor.

Test Plan:
- Reset, defaults (INDEX_BITS=6): deassert nReset, hold predValid=1 -> ready=0 and predTaken=0 for cycles 0..63; ready=1 at cycle 64; predTaken=0 for any PC with INIT_CTR=1.
- Bimodal training, predPC=32'h0000_0040 (index 16):
  - One updTaken=1 -> predTaken=1.
  - Five more taken -> counter saturates at 3.
  - Two not-taken -> counter 1, predTaken=0.
- Gshare aliasing, HIST_BITS=4:
  - Updates taken,taken,not-taken,taken -> GHR=4'b1101.
  - predPC=32'h0000_0000 -> predIndex=6'd13.
  - Same PC in bimodal mode -> predIndex=0.
- Same-cycle hazard: entry 5 at value 1; updValid=1, updIndex=5, updTaken=1 while predPC maps to index 5 -> predTaken=0 this cycle, 1 next cycle.
- Stats:
  - 10 updates, 3 with updMispredict -> branchCount=10, mispredictCount=3.
  - clearStats with a simultaneous update -> both 0.
  - Force branchCount to 32'hFFFF_FFFF, apply one update -> stays 32'hFFFF_FFFF.
- Reset mid-operation: assert nReset at sweep pointer 30, and separately while in RUN -> ready=0 immediately; GHR and stats = 0; full 64-cycle sweep repeats; updValid pulses during the sweep leave stats at 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the dynamic branch predictor.
// Holds the predictor mode and FSM state enums and the saturating counter step.
package coreUtils;

    typedef enum logic {BP_BIMODAL, BP_GSHARE} bp_mode_t;
    typedef enum logic {BP_INIT, BP_RUN} bp_state_t;

    // Move a width-bit counter one step toward taken or not-taken, clamping at both ends.
    function automatic int sat_update(input int ctr, input logic taken, input int width);
        int top;
        top = (1 << width) - 1;
        if (taken)
            return (ctr >= top) ? top : ctr + 1;
        else
            return (ctr <= 0) ? 0 : ctr - 1;
    endfunction

endpackage

// File: rtl/branch_predictor_pht_table.sv
// Pattern history table: one async read port for prediction.
// It also has one write port that either loads a value or steps a counter in place.
module pht_table
    import coreUtils::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2
) (
    input  logic                  Clock,
    input  logic [INDEX_BITS-1:0] rdIndex,
    output logic [CTR_BITS-1:0]   rdCtr,
    input  logic                  wrEnable,
    input  logic                  wrLoad,
    input  logic [INDEX_BITS-1:0] wrIndex,
    input  logic [CTR_BITS-1:0]   wrData,
    input  logic                  wrTaken
);

    logic [CTR_BITS-1:0] ctrArray [1 << INDEX_BITS];
    logic [CTR_BITS-1:0] nextCtr;

    // Async read returns the stored value, so a same-cycle write is seen only next cycle.
    assign rdCtr = ctrArray[rdIndex];

    assign nextCtr = wrLoad ? wrData
                            : CTR_BITS'(sat_update(int'(ctrArray[wrIndex]), wrTaken, CTR_BITS));

    // NOTE: the array has no reset; contents are defined by the init sweep, keeping it RAM-mappable.
    always_ff @(posedge Clock) begin
        if (wrEnable)
            ctrArray[wrIndex] <= nextCtr;
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic conditional-branch predictor (bimodal or gshare) with a post-reset table sweep.
// It also keeps saturating branch and mispredict statistics.
module branch_predictor
    import coreUtils::*;
#(
    parameter int       INDEX_BITS = 6,
    parameter int       CTR_BITS   = 2,
    parameter int       HIST_BITS  = 4,
    parameter bp_mode_t MODE       = BP_GSHARE,
    parameter int       INIT_CTR   = 1
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  predValid,
    input  logic [31:0]           predPC,
    output logic                  predTaken,
    output logic [INDEX_BITS-1:0] predIndex,
    output logic                  ready,
    input  logic                  updValid,
    input  logic [INDEX_BITS-1:0] updIndex,
    input  logic                  updTaken,
    input  logic                  updMispredict,
    input  logic                  clearStats,
    output logic [31:0]           branchCount,
    output logic [31:0]           mispredictCount
);

    localparam int GHR_W    = (HIST_BITS > 0) ? HIST_BITS : 1;
    localparam bit USE_HIST = (MODE == BP_GSHARE) && (HIST_BITS > 0);

    bp_state_t             state;
    logic [INDEX_BITS-1:0] ptr;
    logic [GHR_W-1:0]      ghr;
    logic [GHR_W-1:0]      ghrNext;
    logic [INDEX_BITS-1:0] histExt;
    logic [CTR_BITS-1:0]   rdCtr;
    logic                  updAccept;
    logic                  wrLoad;
    logic                  unusedPcBits;

    assign unusedPcBits = ^{predPC[31:INDEX_BITS+2], predPC[1:0]};

    // NOTE: combinational blocks use blocking assignments and give every output a default first.
    always_comb begin
        histExt = '0;
        if (USE_HIST)
            histExt[GHR_W-1:0] = ghr;
        ghrNext    = ghr << 1;
        ghrNext[0] = updTaken;
    end

    assign predIndex = predPC[INDEX_BITS+1:2] ^ histExt;
    assign predTaken = ready && predValid && rdCtr[CTR_BITS-1];
    assign updAccept = (state == BP_RUN) && updValid;
    assign wrLoad    = (state == BP_INIT);

    pht_table #(
        .INDEX_BITS (INDEX_BITS),
        .CTR_BITS   (CTR_BITS)
    ) u_pht (
        .Clock    (Clock),
        .rdIndex  (predIndex),
        .rdCtr    (rdCtr),
        .wrEnable (wrLoad || updAccept),
        .wrLoad   (wrLoad),
        .wrIndex  (wrLoad ? ptr : updIndex),
        .wrData   (CTR_BITS'(INIT_CTR)),
        .wrTaken  (updTaken)
    );

    // NOTE: sequential state always uses non-blocking assignments.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= BP_INIT;
            ptr   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                BP_INIT: begin
                    ptr <= ptr + INDEX_BITS'(1);
                    if (&ptr) begin
                        state <= BP_RUN;
                        ready <= 1'b1;
                    end
                end
                default: ready <= 1'b1;
            endcase
        end
    end

    // History only advances on resolved branches, so it never needs repair.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
            ghr <= '0;
        else if (updAccept)
            ghr <= ghrNext;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            branchCount     <= '0;
            mispredictCount <= '0;
        end else if (clearStats) begin
            branchCount     <= '0;
            mispredictCount <= '0;
        end else if (updAccept) begin
            if (branchCount != 32'hFFFF_FFFF)
                branchCount <= branchCount + 32'd1;
            if (updMispredict && mispredictCount != 32'hFFFF_FFFF)
                mispredictCount <= mispredictCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor: gshare and bimodal instances share stimulus.
// Both are compared against an array-based reference model plus directed scenario checks.
module tb_branch_predictor;
    import coreUtils::*;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        predValid, updValid, updTaken, updMispredict, clearStats;
    logic [31:0] predPC;
    logic [5:0]  updIndex;

    logic        predTaken_g, predTaken_b, ready_g, ready_b;
    logic [5:0]  predIndex_g, predIndex_b;
    logic [31:0] branchCount_g, branchCount_b, mispredictCount_g, mispredictCount_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain integer counters, history as an integer modulo 16.
    int          pht_g [64];
    int          pht_b [64];
    int          ghr_m;
    int          sweep_m;
    logic [31:0] bc_m, mc_m;

    always #5 Clock = ~Clock;

    branch_predictor dut_g (
        .Clock (Clock), .nReset (nReset), .predValid (predValid), .predPC (predPC),
        .predTaken (predTaken_g), .predIndex (predIndex_g), .ready (ready_g),
        .updValid (updValid), .updIndex (updIndex), .updTaken (updTaken),
        .updMispredict (updMispredict), .clearStats (clearStats),
        .branchCount (branchCount_g), .mispredictCount (mispredictCount_g)
    );

    branch_predictor #(.MODE(BP_BIMODAL)) dut_b (
        .Clock (Clock), .nReset (nReset), .predValid (predValid), .predPC (predPC),
        .predTaken (predTaken_b), .predIndex (predIndex_b), .ready (ready_b),
        .updValid (updValid), .updIndex (updIndex), .updTaken (updTaken),
        .updMispredict (updMispredict), .clearStats (clearStats),
        .branchCount (branchCount_b), .mispredictCount (mispredictCount_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int step_ctr(input int c, input logic t);
        if (t) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    function automatic int idx_b(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int idx_g(input logic [31:0] pc);
        return idx_b(pc) ^ ghr_m;
    endfunction

    // Called at posedge+1 with inputs already driven: check, take the edge, advance the model.
    task automatic cycle();
        bit rdy;
        #1;
        rdy = (sweep_m == 64);
        check("idx_g", 32'(predIndex_g), 32'(idx_g(predPC)));
        check("idx_b", 32'(predIndex_b), 32'(idx_b(predPC)));
        check("pred_g", 32'(predTaken_g), 32'(rdy && predValid && pht_g[idx_g(predPC)] >= 2));
        check("pred_b", 32'(predTaken_b), 32'(rdy && predValid && pht_b[idx_b(predPC)] >= 2));
        check("ready", 32'({ready_g, ready_b}), rdy ? 32'd3 : 32'd0);
        check("bc_g", branchCount_g, bc_m);
        check("mc_g", mispredictCount_g, mc_m);
        check("bc_b", branchCount_b, bc_m);
        check("mc_b", mispredictCount_b, mc_m);
        @(posedge Clock);
        if (clearStats) begin
            bc_m = 0;
            mc_m = 0;
        end
        if (sweep_m < 64) begin
            sweep_m++;
            if (sweep_m == 64)
                for (int i = 0; i < 64; i++) begin
                    pht_g[i] = 1;
                    pht_b[i] = 1;
                end
        end else if (updValid) begin
            pht_g[updIndex] = step_ctr(pht_g[updIndex], updTaken);
            pht_b[updIndex] = step_ctr(pht_b[updIndex], updTaken);
            ghr_m = ((ghr_m << 1) | int'(updTaken)) % 16;
            if (!clearStats) begin
                if (bc_m != 32'hFFFF_FFFF) bc_m++;
                if (updMispredict && mc_m != 32'hFFFF_FFFF) mc_m++;
            end
        end
        #1;
    endtask

    task automatic idle();
        updValid      = 1'b0;
        updTaken      = 1'b0;
        updMispredict = 1'b0;
        clearStats    = 1'b0;
    endtask

    task automatic upd(input int idx, input logic t, input logic m);
        updValid      = 1'b1;
        updIndex      = 6'(idx);
        updTaken      = t;
        updMispredict = m;
        cycle();
        idle();
    endtask

    task automatic randomize_inputs(input bit allow_clear);
        predValid     = 1'($urandom);
        predPC        = $urandom;
        updValid      = 1'($urandom);
        updIndex      = 6'($urandom_range(0, 63));
        updTaken      = 1'($urandom);
        updMispredict = 1'($urandom);
        clearStats    = allow_clear && ($urandom_range(0, 31) == 0);
    endtask

    // Asserted at posedge+1; checks the asynchronous clear before any edge arrives.
    task automatic apply_reset();
        nReset  = 1'b0;
        sweep_m = 0;
        ghr_m   = 0;
        bc_m    = 0;
        mc_m    = 0;
        #1;
        check("rst_ready", 32'({ready_g, ready_b}), 32'd0);
        check("rst_bc", branchCount_g | branchCount_b, 32'd0);
        check("rst_mc", mispredictCount_g | mispredictCount_b, 32'd0);
        @(posedge Clock);
        #1;
        nReset = 1'b1;
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            randomize_inputs(1'b0);
            predValid = 1'b1;
            cycle();
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        nReset = 1'b0;
        predValid = 1'b0;
        predPC = '0;
        updIndex = '0;
        idle();
        @(posedge Clock);
        #1;
        apply_reset();

        // Sweep: ready low for 64 cycles despite predValid and update pulses, then high.
        sweep(64);
        check("ready_rise", 32'({ready_g, ready_b}), 32'd3);
        for (int i = 0; i < 8; i++) begin
            predValid = 1'b1;
            predPC    = $urandom;
            cycle();
            check("init_pred0", 32'({predTaken_g, predTaken_b}), 32'd0);
        end

        // Bimodal training on PC 0x40 (index 16).
        predValid = 1'b1;
        predPC    = 32'h0000_0040;
        upd(16, 1'b1, 1'b0);
        #1 check("bim_t1", 32'(predTaken_b), 32'd1);
        for (int i = 0; i < 5; i++) upd(16, 1'b1, 1'b0);
        upd(16, 1'b0, 1'b0);
        #1 check("bim_sat_n1", 32'(predTaken_b), 32'd1);
        upd(16, 1'b0, 1'b0);
        #1 check("bim_sat_n2", 32'(predTaken_b), 32'd0);

        // History T,T,N,T gives GHR 4'b1101 and gshare index 13 for PC 0.
        upd(40, 1'b1, 1'b0);
        upd(40, 1'b1, 1'b0);
        upd(40, 1'b0, 1'b0);
        upd(40, 1'b1, 1'b0);
        predPC = 32'h0000_0000;
        #1;
        check("gs_idx13", 32'(predIndex_g), 32'd13);
        check("bim_idx0", 32'(predIndex_b), 32'd0);
        cycle();

        // Read-before-write: entry 5 at 1, update taken while predicting from it.
        for (int i = 0; i < 3; i++) upd(5, 1'b0, 1'b0);
        upd(5, 1'b1, 1'b0);
        predPC        = 32'h0000_0014;
        updValid      = 1'b1;
        updIndex      = 6'd5;
        updTaken      = 1'b1;
        #1 check("haz_same", 32'(predTaken_b), 32'd0);
        cycle();
        idle();
        #1 check("haz_next", 32'(predTaken_b), 32'd1);

        // Statistics: clear, 10 updates with 3 mispredicts, then clear racing an update.
        clearStats = 1'b1;
        cycle();
        idle();
        for (int i = 0; i < 10; i++) upd($urandom_range(0, 63), 1'($urandom), i < 3);
        check("stats_bc10", branchCount_b, 32'd10);
        check("stats_mc3", mispredictCount_g, 32'd3);
        clearStats = 1'b1;
        upd(7, 1'b1, 1'b1);
        check("clr_pri_bc", branchCount_g, 32'd0);
        check("clr_pri_mc", mispredictCount_b, 32'd0);

        // Saturation at all-ones.
        force dut_g.branchCount = 32'hFFFF_FFFF;
        force dut_b.branchCount = 32'hFFFF_FFFF;
        force dut_g.mispredictCount = 32'hFFFF_FFFF;
        force dut_b.mispredictCount = 32'hFFFF_FFFF;
        #1;
        release dut_g.branchCount;
        release dut_b.branchCount;
        release dut_g.mispredictCount;
        release dut_b.mispredictCount;
        bc_m = 32'hFFFF_FFFF;
        mc_m = 32'hFFFF_FFFF;
        upd(9, 1'b1, 1'b1);
        check("sat_bc", branchCount_g, 32'hFFFF_FFFF);
        check("sat_mc", mispredictCount_b, 32'hFFFF_FFFF);
        cycle();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs(1'b1);
            cycle();
        end
        idle();

        // Reset with the sweep pointer at 30, then a full sweep again.
        apply_reset();
        sweep(30);
        apply_reset();
        sweep(64);
        for (int i = 0; i < 60; i++) begin
            randomize_inputs(1'b0);
            cycle();
        end
        idle();

        // Reset while running: ready drops immediately, history and stats cleared.
        check("run_ready_pre", 32'(ready_g), 32'd1);
        apply_reset();
        predPC = 32'h0000_0040;
        #1 check("rst_ghr0", 32'(predIndex_g), 32'd16);
        sweep(64);
        for (int i = 0; i < 100; i++) begin
            randomize_inputs(1'b1);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
